// File: rtl/pingpong_bram.sv
// Double-buffered RAM handing frames between a producer and a consumer.
// Two banks swap ownership on explicit done strobes; per-bank full flags give backpressure.
module pingpong_bram #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 6,
  parameter bit          OUT_REG = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_wr_done,
  output logic              o_wr_ready,
  output logic              o_wr_bank,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_done,
  output logic              o_rd_ready,
  output logic              o_rd_bank,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_rd_valid,
  output logic              o_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Both banks live in one array; the bank index is the address MSB.
  logic [WIDTH-1:0] r_mem [2*DEPTH];

  logic [1:0] r_full;
  logic [1:0] w_full_nxt;
  logic       r_wb;
  logic       w_wb_nxt;
  logic       r_rb;
  logic       w_rb_nxt;
  logic       r_err;
  logic       w_err_nxt;

  logic w_wr_ready;
  logic w_rd_ready;
  logic w_wr_acc;
  logic w_wr_done_acc;
  logic w_rd_acc;
  logic w_rd_done_acc;
  logic w_proto_err;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;

  assign w_wr_ready    = ~r_full[r_wb];
  assign w_rd_ready    = r_full[r_rb];
  assign w_wr_acc      = i_wr_en & w_wr_ready;
  assign w_wr_done_acc = i_wr_done & w_wr_ready;
  assign w_rd_acc      = i_rd_en & w_rd_ready;
  assign w_rd_done_acc = i_rd_done & w_rd_ready;
  assign w_proto_err   = ((i_wr_en | i_wr_done) & ~w_wr_ready) |
                         ((i_rd_en | i_rd_done) & ~w_rd_ready);

  // An accepted write-done and read-done always target different banks,
  // since one requires the bank empty and the other requires it full.
  always_comb begin
    w_full_nxt = r_full;
    w_wb_nxt   = r_wb;
    w_rb_nxt   = r_rb;
    w_err_nxt  = r_err | w_proto_err;
    if (w_wr_done_acc) begin
      w_full_nxt[r_wb] = 1'b1;
      w_wb_nxt         = ~r_wb;
    end
    if (w_rd_done_acc) begin
      w_full_nxt[r_rb] = 1'b0;
      w_rb_nxt         = ~r_rb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 2'b00;
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_wb   <= w_wb_nxt;
      r_rb   <= w_rb_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // RAM contents are deliberately left untouched by reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[{r_wb, i_wr_addr}] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= r_mem[{r_rb, i_rd_addr}];
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_s2_valid <= 1'b0;
        r_s2_data  <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign o_rd_valid = r_s2_valid;
    assign o_rd_data  = r_s2_data;
  end else begin : g_no_out_reg
    assign o_rd_valid = r_s1_valid;
    assign o_rd_data  = r_s1_data;
  end

  assign o_wr_ready = w_wr_ready;
  assign o_rd_ready = w_rd_ready;
  assign o_wr_bank  = r_wb;
  assign o_rd_bank  = r_rb;
  assign o_err      = r_err;

endmodule
